golden_nonce_reporter: RTL and testbench

- Sits directly downstream of the miner core and consumes its `golden_nonce` output.
- Detects each newly reported golden nonce and queues it in a small FIFO.
- Serializes queued nonces as 4-byte little-endian frames on a valid/ready byte stream. The host-link UART transmitter drains that stream.
- Decouples bursty nonce discovery from the slow serial link and counts results lost to overflow.

---
 rtl/golden_nonce_reporter_if.sv | 9 +
 rtl/golden_nonce_reporter.sv | 133 +++++++++++++
 tb/tb_golden_nonce_reporter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/golden_nonce_reporter_if.sv
// Byte stream carrying serialized golden nonces to the host-link UART.
interface golden_nonce_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/golden_nonce_reporter.sv
// Queues newly reported golden nonces and streams them as little-endian byte frames.
// Define GOLDEN_REPORTER_HEADER_EN to prefix each frame with an 8'hA5 header byte.
module golden_nonce_reporter #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             golden_nonce,
    golden_nonce_reporter_if.master tx,
    output logic [DEPTH_LOG2:0]     fifo_level,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output logic                    busy
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
`ifdef GOLDEN_REPORTER_HEADER_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [31:0]     prev_q, prev_d;
    logic [31:0]     shift_q, shift_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_count_q, drop_count_d;
    logic [31:0]     mem_q [DEPTH];

    logic            new_event, empty, full, push, pop, drop;
    logic            tx_valid;
    logic [7:0]      tx_data;

    always_comb begin
        new_event = (golden_nonce != prev_q) && !reset;
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                    (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[PW-2:0]];
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
`ifdef GOLDEN_REPORTER_HEADER_EN
                tx_data  = (idx_q == 3'd0) ? 8'hA5 : shift_q[7:0];
`else
                tx_data  = shift_q[7:0];
`endif
                if (tx.tx_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 3'd1;
`ifdef GOLDEN_REPORTER_HEADER_EN
                        // the header byte does not consume nonce bits
                        if (idx_q != 3'd0) shift_d = shift_q >> 8;
`else
                        shift_d = shift_q >> 8;
`endif
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q[PW-2:0]];
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // a pop in the same cycle frees a slot, so a full FIFO still accepts
        push = new_event && (!full || pop);
        drop = new_event && !push;

        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        prev_d       = golden_nonce;
        overflow_d   = overflow_q | drop;
        drop_count_d = (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // storage needs no reset: push is masked while reset is high
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-2:0]] <= golden_nonce;
    end

    assign tx.tx_valid  = tx_valid;
    assign tx.tx_data   = tx_data;
    assign fifo_level   = wr_ptr_q - rd_ptr_q;
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign busy         = (state_q == SEND) || (fifo_level != '0);
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed checks of nonce detection, FIFO queuing and byte-frame serialization.
module tb_golden_nonce_reporter;
`ifdef GOLDEN_REPORTER_HEADER_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] golden_nonce;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        busy;

    golden_nonce_reporter_if bus ();

    golden_nonce_reporter #(.DEPTH_LOG2(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .golden_nonce (golden_nonce),
        .tx           (bus.master),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc_n = 0;
    int         peak = 0;
    logic [7:0] hs_q[$];
    int         hs_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected byte i of the frame carrying nonce n
    function automatic logic [7:0] exp_byte(input logic [31:0] n, input int i);
        logic [31:0] s;
        int          k;
        k = i;
`ifdef GOLDEN_REPORTER_HEADER_EN
        if (i == 0) return 8'hA5;
        k = i - 1;
`endif
        s = n >> (8 * k);
        return s[7:0];
    endfunction

    // one clock: log the handshake taken at this edge, then check stall stability
    task automatic cyc();
        logic       sv, sr, rw;
        logic [7:0] sd;
        sv = bus.tx_valid; sr = bus.tx_ready; sd = bus.tx_data; rw = reset;
        if (sv && sr && !rw) begin
            hs_q.push_back(sd);
            hs_cyc.push_back(cyc_n);
        end
        @(posedge clk); #1;
        cyc_n++;
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        if (sv && !sr && !rw && !reset) begin
            chk("stall_valid", 32'(bus.tx_valid), 32'd1);
            chk("stall_data", 32'(bus.tx_data), 32'(sd));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; golden_nonce = '0; bus.tx_ready = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        hs_q.delete(); hs_cyc.delete(); peak = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk_frames(input string tag, input logic [31:0] nonces[$]);
        chk({tag, "_count"}, 32'(hs_q.size()), 32'(nonces.size() * FL));
        for (int f = 0; f < nonces.size(); f++)
            for (int b = 0; b < FL; b++)
                if (f * FL + b < hs_q.size())
                    chk({tag, "_byte"}, 32'(hs_q[f * FL + b]), 32'(exp_byte(nonces[f], b)));
    endtask

    initial begin
        logic [31:0] nl[$];
        int          guard;

        reset = 1'b1; golden_nonce = '0; bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        chk("rst_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single nonce: valid appears two edges after the change
        golden_nonce = 32'hDEADBEEF;
        cyc();
        chk("single_valid_e1", 32'(bus.tx_valid), 32'd0);
        chk("single_level_e1", 32'(fifo_level), 32'd1);
        cyc();
        for (int b = 0; b < FL; b++) begin
            chk("single_valid", 32'(bus.tx_valid), 32'd1);
            chk("single_data", 32'(bus.tx_data), 32'(exp_byte(32'hDEADBEEF, b)));
            cyc();
        end
        chk("single_idle_valid", 32'(bus.tx_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);

        // backpressure with ready pattern 1,0,0,1
        do_reset();
        golden_nonce = 32'hDEADBEEF;
        for (int i = 0; i < 40; i++) begin
            bus.tx_ready = (i % 4 == 0) || (i % 4 == 3);
            cyc();
        end
        bus.tx_ready = 1'b1;
        nl = '{32'hDEADBEEF};
        chk_frames("bp", nl);

        // burst of three consecutive changes, frames back to back
        do_reset();
        golden_nonce = 32'd1; cyc();
        golden_nonce = 32'd2; cyc();
        golden_nonce = 32'd3; cyc();
        run(20);
        chk("burst_peak", 32'(peak), 32'd2);
        nl = '{32'd1, 32'd2, 32'd3};
        chk_frames("burst", nl);
        if (hs_cyc.size() == 3 * FL)
            chk("burst_gapless", 32'(hs_cyc[3 * FL - 1] - hs_cyc[0]), 32'(3 * FL - 1));

        // overflow: 11 changes while stalled, depth 8
        do_reset();
        bus.tx_ready = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            golden_nonce = 32'(k);
            cyc();
        end
        chk("ovf_level", 32'(fifo_level), 32'd8);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_valid", 32'(bus.tx_valid), 32'd1);
        chk("ovf_head", 32'(bus.tx_data), 32'(exp_byte(32'd1, 0)));
        bus.tx_ready = 1'b1;
        run(9 * FL + 5);
        nl = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        chk_frames("ovf", nl);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_drop_hold", 32'(drop_count), 32'd2);

        // reset during byte 2 of a frame, with the overflow state still set
        hs_q.delete(); hs_cyc.delete();
        golden_nonce = 32'h11223344;
        guard = 0;
        while (hs_q.size() < 2 && guard < 20) begin
            cyc();
            guard++;
        end
        chk("mid_reached", 32'(hs_q.size()), 32'd2);
        reset = 1'b1; golden_nonce = '0;
        cyc();
        reset = 1'b0;
        chk("mid_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid_level", 32'(fifo_level), 32'd0);
        chk("mid_ovf", 32'(overflow), 32'd0);
        chk("mid_drop", 32'(drop_count), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        hs_q.delete(); hs_cyc.delete();
        run(12);
        chk("mid_no_resume", 32'(hs_q.size()), 32'd0);

        // held value is never reported; a change then a revert reports both
        do_reset();
        run(20);
        chk("dup_zero", 32'(hs_q.size()), 32'd0);
        golden_nonce = 32'h12345678;
        run(20 + FL);
        nl = '{32'h12345678};
        chk_frames("dup_hold", nl);
        hs_q.delete(); hs_cyc.delete();
        golden_nonce = 32'h0000AB00; cyc();
        golden_nonce = 32'h12345678;
        run(3 * FL);
        nl = '{32'h0000AB00, 32'h12345678};
        chk_frames("revert", nl);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
